// File: rtl/gate_tt_checker.sv
// Walks a 2-input gate through {a,b}=00..11, samples y SETTLE+2 cycles per vector, scores against a golden table.
// done pulses 4*(SETTLE+2) cycles after the start-accepting edge; start is ignored (never queued) while a pass runs.
module gate_tt_checker #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] result,
  output logic [2:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam bit         HAS_WAIT  = (SETTLE > 0);
  localparam logic [3:0] WAIT_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] idx_q;
  logic [3:0] wait_cnt_q;
  logic [3:0] exp_q;
  logic       wait_last;
  logic       y_match;

  assign wait_last = (wait_cnt_q == WAIT_LAST);

  // Only an exact 0/1 match counts; an unknown y falls through to a mismatch.
  always_comb begin
    y_match = 1'b0;
    if (y == exp_q[idx_q]) begin
      y_match = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_DRIVE;
      S_DRIVE:  state_d = HAS_WAIT ? S_WAIT : S_SAMPLE;
      S_WAIT:   if (wait_last) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (idx_q == 2'd3) ? S_DONE : S_DRIVE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a    = 1'b0;
    b    = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_DRIVE, S_WAIT, S_SAMPLE: begin
        a    = idx_q[1];
        b    = idx_q[0];
        busy = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= 2'd0;
      wait_cnt_q <= 4'd0;
      exp_q      <= 4'd0;
      result     <= 4'd0;
      err_count  <= 3'd0;
      pass       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            exp_q     <= expected;
            result    <= 4'd0;
            err_count <= 3'd0;
            pass      <= 1'b0;
            idx_q     <= 2'd0;
          end
        end
        S_DRIVE: wait_cnt_q <= 4'd0;
        S_WAIT:  wait_cnt_q <= wait_cnt_q + 4'd1;
        S_SAMPLE: begin
          result[idx_q] <= y;
          if (!y_match && (err_count != 3'd7)) begin
            err_count <= err_count + 3'd1;
          end
          if (idx_q != 2'd3) begin
            idx_q <= idx_q + 2'd1;
          end
        end
        S_DONE:  pass <= (err_count == 3'd0);
        default: ;
      endcase
    end
  end

  // Structural invariants of the pass sequencing.
  a_done_single : assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
  a_busy_done   : assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
  a_err_range   : assert property (@(posedge clk) disable iff (!rst_n) err_count <= 3'd4);
  a_wait_stable : assert property (@(posedge clk) disable iff (!rst_n)
                                   (state_q == S_WAIT) |-> ($stable(a) && $stable(b)));

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: SETTLE=1 and SETTLE=0 instances, each driving a table-defined gate model,
// checked every cycle against a pass-level timing model plus hand-computed scenario results.
module tb_gate_tt_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       start_s    [2];
  logic [3:0] expected_s [2];
  logic       y_s        [2];
  logic       a_s        [2];
  logic       b_s        [2];
  logic       busy_s     [2];
  logic       done_s     [2];
  logic       pass_s     [2];
  logic [3:0] result_s   [2];
  logic [2:0] err_s      [2];
  logic [3:0] gtt        [2];

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  assign y_s[0] = gtt[0][{a_s[0], b_s[0]}];
  assign y_s[1] = gtt[1][{a_s[1], b_s[1]}];

  gate_tt_checker #(.SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .expected(expected_s[0]), .y(y_s[0]),
    .a(a_s[0]), .b(b_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .result(result_s[0]), .err_count(err_s[0])
  );

  gate_tt_checker #(.SETTLE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .expected(expected_s[1]), .y(y_s[1]),
    .a(a_s[1]), .b(b_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .result(result_s[1]), .err_count(err_s[1])
  );

  // Cycles per vector for each instance (SETTLE + 2).
  function automatic int per(input int i);
    return (i == 0) ? 3 : 2;
  endfunction

  function automatic void chk(input string nm, input int i, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0d want %0d at %0t", nm, i, act, exp, $time);
  endfunction

  // Pass-level model: phase 0 idle, 1 running (c = cycles since acceptance), 2 done cycle.
  int         m_phase [2] = '{0, 0};
  int         m_c     [2] = '{0, 0};
  logic [3:0] m_exp   [2] = '{4'd0, 4'd0};
  logic [3:0] m_res   [2] = '{4'd0, 4'd0};
  int         m_err   [2] = '{0, 0};
  logic       m_pass  [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin : model
    for (int i = 0; i < 2; i++) begin
      int   p;
      int   v;
      logic yb;
      p  = per(i);
      v  = m_c[i] / p;
      yb = gtt[i][v % 4];
      if (!rst_n) begin
        m_phase[i] <= 0;
        m_c[i]     <= 0;
        m_res[i]   <= 4'd0;
        m_err[i]   <= 0;
        m_pass[i]  <= 1'b0;
      end else begin
        case (m_phase[i])
          0: if (start_s[i]) begin
            m_phase[i] <= 1;
            m_c[i]     <= 0;
            m_exp[i]   <= expected_s[i];
            m_res[i]   <= 4'd0;
            m_err[i]   <= 0;
            m_pass[i]  <= 1'b0;
          end
          1: begin
            if (m_c[i] % p == p - 1) begin
              m_res[i][v % 4] <= yb;
              if (yb != m_exp[i][v % 4]) m_err[i] <= m_err[i] + 1;
            end
            m_c[i] <= m_c[i] + 1;
            if (m_c[i] + 1 == 4 * p) m_phase[i] <= 2;
          end
          default: begin
            m_pass[i]  <= (m_err[i] == 0);
            m_phase[i] <= 0;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int v;
        int run;
        run = (m_phase[i] == 1) ? 1 : 0;
        v   = m_c[i] / per(i);
        chk("a",      i, a_s[i],      run ? v[1] : 0);
        chk("b",      i, b_s[i],      run ? v[0] : 0);
        chk("busy",   i, busy_s[i],   run);
        chk("done",   i, done_s[i],   (m_phase[i] == 2) ? 1 : 0);
        chk("pass",   i, pass_s[i],   m_pass[i]);
        chk("result", i, result_s[i], m_res[i]);
        chk("err",    i, err_s[i],    m_err[i]);
      end
    end
  end

  // One start pulse from idle; returns edges from acceptance to done, {a,b} trace while busy, final results.
  task automatic run_pass(input int i, input logic [3:0] ex, input logic [3:0] g,
                          output int e, output logic [15:0] seq,
                          output logic [3:0] r, output logic [2:0] er, output logic ps);
    @(negedge clk);
    expected_s[i] = ex;
    gtt[i]        = g;
    start_s[i]    = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
    e   = 0;
    seq = 16'd0;
    if (busy_s[i]) seq = {seq[13:0], a_s[i], b_s[i]};
    while (!done_s[i] && e < 200) begin
      @(negedge clk);
      e++;
      if (busy_s[i]) seq = {seq[13:0], a_s[i], b_s[i]};
    end
    if (e >= 200) chk("done_timeout", i, 0, 1);
    r  = result_s[i];
    er = err_s[i];
    @(negedge clk);
    ps = pass_s[i];
  endtask

  task automatic count_done(input int i, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done_s[i]) cnt++;
    end
  endtask

  initial begin
    int         e;
    int         cnt;
    logic [15:0] seq;
    logic [3:0] r;
    logic [2:0] er;
    logic       ps;

    for (int i = 0; i < 2; i++) begin
      start_s[i]    = 1'b0;
      expected_s[i] = 4'b0001;
      gtt[i]        = 4'b0001;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy",   i, busy_s[i],   0);
      chk("rst_done",   i, done_s[i],   0);
      chk("rst_result", i, result_s[i], 0);
      chk("rst_err",    i, err_s[i],    0);
    end
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Correct NOR gate, SETTLE=1.
    run_pass(0, 4'b0001, 4'b0001, e, seq, r, er, ps);
    chk("nor_latency", 0, e, 12);
    chk("nor_result",  0, r, 4'b0001);
    chk("nor_err",     0, er, 0);
    chk("nor_pass",    0, ps, 1);

    // AND gate substituted.
    run_pass(0, 4'b0001, 4'b1000, e, seq, r, er, ps);
    chk("and_result", 0, r, 4'b1000);
    chk("and_err",    0, er, 2);
    chk("and_pass",   0, ps, 0);

    // y stuck at 0.
    run_pass(0, 4'b0001, 4'b0000, e, seq, r, er, ps);
    chk("stuck_result", 0, r, 4'b0000);
    chk("stuck_err",    0, er, 1);
    chk("stuck_pass",   0, ps, 0);

    // Zero settle: 8 edges, each vector held two cycles.
    run_pass(1, 4'b0001, 4'b0001, e, seq, r, er, ps);
    chk("s0_latency", 1, e, 8);
    chk("s0_ab_seq",  1, seq, 16'h05AF);
    chk("s0_result",  1, r, 4'b0001);
    chk("s0_pass",    1, ps, 1);

    // Second start while busy is dropped.
    gtt[0] = 4'b0001;
    @(negedge clk) start_s[0] = 1'b1;
    @(negedge clk) start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk) start_s[0] = 1'b0;
    count_done(0, 25, cnt);
    chk("busy_start_dones", 0, cnt, 1);
    chk("busy_start_result", 0, result_s[0], 4'b0001);

    // Start held high: one idle cycle between passes.
    @(negedge clk) start_s[0] = 1'b1;
    e = 0;
    while (!done_s[0] && e < 40) begin @(negedge clk); e++; end
    @(negedge clk);
    e = 1;
    while (!done_s[0] && e < 40) begin @(negedge clk); e++; end
    chk("held_period", 0, e, 14);
    start_s[0] = 1'b0;
    repeat (20) @(negedge clk);

    // Reset in the middle of vector 2.
    @(negedge clk) start_s[0] = 1'b1;
    @(negedge clk) start_s[0] = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_a",      0, a_s[0],      0);
    chk("mid_rst_busy",   0, busy_s[0],   0);
    chk("mid_rst_result", 0, result_s[0], 0);
    chk("mid_rst_err",    0, err_s[0],    0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    count_done(0, 20, cnt);
    chk("mid_rst_dones", 0, cnt, 0);
    chk("mid_rst_idle",  0, busy_s[0], 0);
    run_pass(0, 4'b0001, 4'b0001, e, seq, r, er, ps);
    chk("post_rst_latency", 0, e, 12);
    chk("post_rst_result",  0, r, 4'b0001);
    chk("post_rst_pass",    0, ps, 1);

    // Randomized traffic, gate tables and occasional resets.
    repeat (900) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        start_s[i]    = ($urandom_range(0, 2) == 0);
        expected_s[i] = 4'($urandom);
        if ($urandom_range(0, 40) == 0) gtt[i] = 4'($urandom);
      end
      if ($urandom_range(0, 250) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    repeat (30) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gate_tt_checker.md
GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
REQ-001 The clock and reset SHALL be one clock `clk` and an asynchronous, active-low reset `rst_n`.
REQ-002 Parameter SETTLE, default 1: number of wait cycles between driving a vector and sampling y; legal range 0..15.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to run one truth-table pass; acted on only in IDLE.
REQ-006 expected  input  4  golden truth table, bit index = {a,b}; latched when start is accepted.
REQ-007 y  input  1  output of the 2-input gate under test.
REQ-008 a  output  1  gate input A, driven by the checker.
REQ-009 b  output  1  gate input B, driven by the checker.
REQ-010 busy  output  1  high from the cycle after start is accepted until DONE is entered.
REQ-011 done  output  1  one-cycle pulse marking the end of a pass.
REQ-012 pass  output  1  high when the last completed pass had zero mismatches; held until the next start is accepted.
REQ-013 result  output  4  captured y per vector, bit index = {a,b}.
REQ-014 err_count  output  3  mismatch count for the current or last pass, range 0..4.

Function
REQ-015 The FSM SHALL have the states IDLE, DRIVE, WAIT, SAMPLE and DONE, with a 2-bit vector index idx.
REQ-016 IDLE behaviour: on start=1 at a rising edge, the block SHALL latch expected, clear result, err_count, pass and idx, then go to DRIVE; with start=0 it SHALL stay in IDLE.
REQ-017 DRIVE behaviour: a=idx[1], b=idx[0]; one cycle; next state is WAIT if SETTLE>0, otherwise SAMPLE.
REQ-018 WAIT behaviour: exactly SETTLE cycles, tracked by an internal counter; a and b stay stable; next state is SAMPLE.
REQ-019 SAMPLE behaviour: result[idx]<=y; if y differs from the latched expected[idx], err_count increments by 1; a and b stay stable.
REQ-020 SAMPLE exit: if idx==3, go to DONE; otherwise idx increments and the FSM goes to DRIVE.
REQ-021 Vector order SHALL be {a,b} = 00, 01, 10, 11; each vector takes SETTLE+2 cycles.
REQ-022 Latency: done SHALL be high in the cycle following the (4*(SETTLE+2))th edge after the start-accepting edge; for SETTLE=1, that is after the 12th edge.
REQ-023 DONE behaviour: done=1 and busy=0 for one cycle; pass<=(err_count==0); next state is IDLE unconditionally.
REQ-024 Outputs in IDLE and DONE: a=b=0.
REQ-025 Start during a pass: start asserted in DRIVE, WAIT, SAMPLE or DONE SHALL be ignored and SHALL NOT be queued.
REQ-026 Start held high continuously: the block SHALL spend 1 cycle in IDLE between passes, then restart.
REQ-027 Sampling rule: a y value other than 0 or 1 at SAMPLE SHALL count as a mismatch.
REQ-028 Error counter: err_count SHALL NOT wrap, since its maximum reachable value is 4.
REQ-029 Post-pass holding: result and err_count SHALL hold after DONE until the next accepted start.

Reset
REQ-030 Asynchronous reset: rst_n=0 SHALL immediately force state=IDLE, idx=0, and a, b, busy, done, pass, result and err_count all to 0, and clear the wait counter.
REQ-031 Reset mid-pass: reset asserted during a pass SHALL abort it with no done pulse; after release, the block SHALL wait in IDLE for a new start.
REQ-032 Reset release: the first start is accepted on the first rising edge where rst_n=1 and start=1.

Verification
REQ-033 Scenario, correct gate: a NOR gate on a,b,y, expected=4'b0001, SETTLE=1, start pulse -> done pulse 13 cycles after start; result=4'b0001; err_count=0; pass=1.
REQ-034 Scenario, wrong gate: an AND gate substituted, expected=4'b0001 -> result=4'b1000; err_count=2; pass=0.
REQ-035 Scenario, zero settle: SETTLE=0 with a NOR gate -> done on the 9th edge after start; a,b sequence 00,01,10,11, each held 2 cycles.
REQ-036 Scenario, start while busy: a second start pulse while busy=1 -> no restart; exactly one done pulse; results unaffected.
REQ-037 Scenario, reset mid-pass: rst_n low during vector 2 -> all outputs 0 at once; no done pulse; a new start then completes a normal pass.
REQ-038 Scenario, stuck output: y tied to 0 with expected=4'b0001 -> err_count=1; result=4'b0000; pass=0.
